// File: rtl/dot_accum_16bit.sv
`default_nettype none
// ============================================================================
// Module   : dot_accum_16bit
// Brief    : Saturating dot-product accumulator over groups of LEN products,
//            with a 2-entry valid/ready result FIFO and sticky drop flag.
// Revision : 1.0 - initial release
// ============================================================================
module dot_accum_16bit #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 20,
    parameter int LEN    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prod_en,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              flush,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_sat,
    output logic              drop_err,
    output logic [7:0]        cnt
);

    localparam logic [7:0]       c_last_idx = 8'(LEN - 1);
    localparam logic [ACC_W-1:0] c_acc_max  = '1;

    logic [ACC_W-1:0] r_acc;
    logic             r_sat;
    logic [7:0]       r_cnt;

    logic [ACC_W-1:0] r_data [2];
    logic             r_fsat [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;
    logic             r_drop;

    logic [ACC_W:0]   w_prod_ext;
    logic [ACC_W:0]   w_sum;
    logic             w_ovf;
    logic [ACC_W-1:0] w_acc_next;
    logic             w_sat_next;
    logic             w_done;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;

    // One extra bit on the adder exposes the carry used for saturation.
    assign w_prod_ext = {{(ACC_W + 1 - PROD_W){1'b0}}, prod_in};
    assign w_sum      = {1'b0, r_acc} + w_prod_ext;
    assign w_ovf      = w_sum[ACC_W];
    assign w_acc_next = w_ovf ? c_acc_max : w_sum[ACC_W-1:0];
    assign w_sat_next = r_sat | w_ovf;
    assign w_done     = prod_en & ~flush & (r_cnt == c_last_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_sat <= 1'b0;
            r_cnt <= '0;
        end else if (flush || w_done) begin
            r_acc <= '0;
            r_sat <= 1'b0;
            r_cnt <= '0;
        end else if (prod_en) begin
            r_acc <= w_acc_next;
            r_sat <= w_sat_next;
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign w_empty = (r_count == 2'd0);
    assign w_full  = (r_count == 2'd2);
    assign w_pop   = ~w_empty & acc_ready;
    // A pop on the same edge frees the head slot, which is where wptr points when full.
    assign w_push  = w_done & (~w_full | w_pop);
    assign w_drop  = w_done & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data[0] <= '0;
            r_data[1] <= '0;
            r_fsat[0] <= 1'b0;
            r_fsat[1] <= 1'b0;
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_count   <= '0;
            r_drop    <= 1'b0;
        end else begin
            if (w_push) begin
                r_data[r_wptr] <= w_acc_next;
                r_fsat[r_wptr] <= w_sat_next;
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            if (w_drop) begin
                r_drop <= 1'b1;
            end
        end
    end

    assign acc_valid = ~w_empty;
    assign acc_out   = w_empty ? '0 : r_data[r_rptr];
    assign acc_sat   = ~w_empty & r_fsat[r_rptr];
    assign drop_err  = r_drop;
    assign cnt       = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dot_accum_16bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_dot_accum_16bit
// Brief    : Directed and random checks of dot_accum_16bit (ACC_W 20 and 18)
//            against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dot_accum_16bit;

    localparam int c_len = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        prod_en;
    logic [15:0] prod_in;
    logic        flush;
    logic        acc_ready;

    logic        valid_a, sat_a, drop_a;
    logic [19:0] out_a;
    logic [7:0]  cnt_a;
    logic        valid_b, sat_b, drop_b;
    logic [17:0] out_b;
    logic [7:0]  cnt_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state, index 0 = ACC_W 20, index 1 = ACC_W 18
    longint m_max  [2];
    longint m_acc  [2];
    bit     m_sat  [2];
    int     m_cnt  [2];
    bit     m_drop [2];
    longint m_q_v  [2][$];
    bit     m_q_s  [2][$];

    always #5 clk = ~clk;

    dot_accum_16bit #(.PROD_W(16), .ACC_W(20), .LEN(c_len)) dut_a (
        .clk(clk), .rst(rst), .prod_en(prod_en), .prod_in(prod_in), .flush(flush),
        .acc_valid(valid_a), .acc_ready(acc_ready), .acc_out(out_a),
        .acc_sat(sat_a), .drop_err(drop_a), .cnt(cnt_a)
    );

    dot_accum_16bit #(.PROD_W(16), .ACC_W(18), .LEN(c_len)) dut_b (
        .clk(clk), .rst(rst), .prod_en(prod_en), .prod_in(prod_in), .flush(flush),
        .acc_valid(valid_b), .acc_ready(acc_ready), .acc_out(out_b),
        .acc_sat(sat_b), .drop_err(drop_b), .cnt(cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            bit     do_push;
            longint rv;
            bit     rs;
            longint sum;
            do_push = 1'b0;
            rv      = 0;
            rs      = 1'b0;
            if (rst) begin
                m_acc[d]  = 0;
                m_sat[d]  = 1'b0;
                m_cnt[d]  = 0;
                m_drop[d] = 1'b0;
                m_q_v[d].delete();
                m_q_s[d].delete();
                continue;
            end
            if (flush) begin
                m_acc[d] = 0;
                m_sat[d] = 1'b0;
                m_cnt[d] = 0;
            end else if (prod_en) begin
                sum = m_acc[d] + longint'(prod_in);
                if (sum > m_max[d]) begin
                    m_acc[d] = m_max[d];
                    m_sat[d] = 1'b1;
                end else begin
                    m_acc[d] = sum;
                end
                if (m_cnt[d] == c_len - 1) begin
                    do_push  = 1'b1;
                    rv       = m_acc[d];
                    rs       = m_sat[d];
                    m_acc[d] = 0;
                    m_sat[d] = 1'b0;
                    m_cnt[d] = 0;
                end else begin
                    m_cnt[d]++;
                end
            end
            if (m_q_v[d].size() > 0 && acc_ready) begin
                void'(m_q_v[d].pop_front());
                void'(m_q_s[d].pop_front());
            end
            if (do_push) begin
                if (m_q_v[d].size() < 2) begin
                    m_q_v[d].push_back(rv);
                    m_q_s[d].push_back(rs);
                end else begin
                    m_drop[d] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            bit     ev;
            longint eo;
            bit     es;
            ev = (m_q_v[d].size() > 0);
            eo = ev ? m_q_v[d][0] : 0;
            es = ev ? m_q_s[d][0] : 1'b0;
            if (d == 0) begin
                check("a_valid", 32'(valid_a), 32'(ev));
                check("a_out",   32'(out_a),   32'(eo));
                check("a_sat",   32'(sat_a),   32'(es));
                check("a_drop",  32'(drop_a),  32'(m_drop[0]));
                check("a_cnt",   32'(cnt_a),   32'(m_cnt[0]));
            end else begin
                check("b_valid", 32'(valid_b), 32'(ev));
                check("b_out",   32'(out_b),   32'(eo));
                check("b_sat",   32'(sat_b),   32'(es));
                check("b_drop",  32'(drop_b),  32'(m_drop[1]));
                check("b_cnt",   32'(cnt_b),   32'(m_cnt[1]));
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic put(input logic [15:0] p);
        prod_en = 1'b1;
        prod_in = p;
        cyc();
        prod_en = 1'b0;
    endtask

    task automatic idle(input int n);
        prod_en = 1'b0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        m_max[0] = (longint'(1) << 20) - 1;
        m_max[1] = (longint'(1) << 18) - 1;
        rst = 1'b1; prod_en = 1'b0; prod_in = '0; flush = 1'b0; acc_ready = 1'b1;
        cyc(); cyc();
        rst = 1'b0;

        // Reset in the middle of a vector
        for (int i = 0; i < 5; i++) put(16'd7);
        check("cnt_before_rst", 32'(cnt_a), 32'd5);
        rst = 1'b1;
        prod_en = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        prod_en = 1'b0;
        check("rst_cnt", 32'(cnt_a), 32'd0);
        check("rst_valid", 32'(valid_a), 32'd0);
        for (int i = 0; i < 8; i++) put(16'd1);
        check("ones_sum", 32'(out_a), 32'd8);
        idle(1);

        // Basic sum 1..8
        for (int i = 1; i <= 8; i++) put(16'(i));
        check("basic_valid", 32'(valid_a), 32'd1);
        check("basic_sum", 32'(out_a), 32'd36);
        idle(1);
        check("basic_valid_1cyc", 32'(valid_a), 32'd0);
        check("basic_cnt", 32'(cnt_a), 32'd0);

        // Max products on both widths
        for (int i = 0; i < 8; i++) put(16'd65025);
        check("max20_sum", 32'(out_a), 32'd520200);
        check("max20_sat", 32'(sat_a), 32'd0);
        check("max18_sum", 32'(out_b), 32'd262143);
        check("max18_sat", 32'(sat_b), 32'd1);
        idle(1);

        // Gaps and flush beating a simultaneous product
        put(16'd100);
        put(16'd200);
        idle(3);
        flush = 1'b1;
        put(16'd500);
        flush = 1'b0;
        check("flush_cnt", 32'(cnt_a), 32'd0);
        check("flush_valid", 32'(valid_a), 32'd0);
        for (int i = 0; i < 8; i++) put(16'd10);
        check("after_flush_sum", 32'(out_a), 32'd80);
        idle(1);

        // Backpressure with a dropped third result
        acc_ready = 1'b0;
        for (int i = 0; i < 24; i++) put(16'd2);
        check("bp_drop", 32'(drop_a), 32'd1);
        check("bp_head", 32'(out_a), 32'd16);
        acc_ready = 1'b1;
        idle(1);
        check("bp_pop1_valid", 32'(valid_a), 32'd1);
        check("bp_pop1_head", 32'(out_a), 32'd16);
        idle(1);
        check("bp_empty", 32'(valid_a), 32'd0);

        // Simultaneous push and pop on a full FIFO
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        acc_ready = 1'b0;
        for (int i = 0; i < 16; i++) put(16'd2);
        for (int i = 0; i < 7; i++) put(16'd3);
        acc_ready = 1'b1;
        put(16'd3);
        check("full_pp_drop", 32'(drop_a), 32'd0);
        check("full_pp_head", 32'(out_a), 32'd16);
        idle(1);
        check("full_pp_second", 32'(out_a), 32'd24);
        idle(1);
        check("full_pp_empty", 32'(valid_a), 32'd0);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            prod_en   = ($urandom_range(0, 3) != 0);
            prod_in   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            flush     = ($urandom_range(0, 39) == 0);
            acc_ready = ($urandom_range(0, 2) != 0);
            cyc();
        end
        rst = 1'b0; prod_en = 1'b0; flush = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
